shift_unit_seq: RTL
===================

SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits; legal values are powers of two, 4 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width; shamt ranges 0..WIDTH-1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; SHALL be sampled only in IDLE.
REQ-006 A  input  WIDTH  operand; SHALL be captured on the accepting edge.
REQ-007 shamt  input  SHW  shift amount; SHALL be captured on the accepting edge.
REQ-008 mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL (see REQ-025); SHALL be captured on the accepting edge.
REQ-009 S  output  WIDTH  result register.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  registered one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1: on that edge, S<=A, count<=shamt, op<=mode; next state SHALL be SHIFT if shamt!=0, else DONE.
REQ-014 SHIFT: each edge SHALL shift S by exactly one bit per the captured op and decrement count; when count==1, next state SHALL be DONE.
REQ-015 DONE: done=1 for exactly that cycle; next state SHALL be IDLE unconditionally.
REQ-016 Latency: done SHALL be high in the cycle after the (shamt+1)-th rising edge, counting the accepting edge as edge 1.
REQ-017 SLL SHALL shift in 0 at bit 0; SRL SHALL shift in 0 at bit WIDTH-1; SRA SHALL replicate bit WIDTH-1.
REQ-018 Bits shifted out SHALL be discarded; there is no carry or overflow output.
REQ-019 start in SHIFT or DONE SHALL be ignored; A, shamt and mode changes while busy SHALL NOT affect the operation in progress.
REQ-020 S SHALL hold the final result from DONE until the next accepted start.
REQ-021 A start in the IDLE cycle immediately following DONE SHALL be accepted (back-to-back operation).

Reset
REQ-022 When reset=0, the block SHALL immediately, without waiting for a clock edge, set state to IDLE, S to 0, count to 0, busy to 0 and done to 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.
REQ-024 After reset deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-025 Macro SHIFT_ROTATE_EN defined: mode 11 SHALL rotate left by one bit per SHIFT cycle (bit WIDTH-1 moves into bit 0).
REQ-026 Macro SHIFT_ROTATE_EN undefined: mode 11 SHALL behave exactly as SLL, and no rotate logic SHALL be synthesised.

Verification (WIDTH=16)
REQ-027 A=3782 (0x0EC6), shamt=2, mode=SLL, start pulse -> S=15128 (0x3B18); done high one cycle after the 3rd edge; busy low afterwards.
REQ-028 A=0x8001, shamt=4: mode=SRA -> S=0xF800; mode=SRL -> S=0x0800.
REQ-029 A=0x8001, shamt=1, mode=11 -> S=0x0003 with SHIFT_ROTATE_EN, S=0x0002 without it.
REQ-030 A=0x1234, shamt=0, mode=SLL -> S=0x1234; done high in the cycle after the accepting edge; busy high for that one cycle only.
REQ-031 A=0x00FF, shamt=8, SLL; second start with A=0xFFFF asserted 3 cycles later -> second start ignored; S=0xFF00; exactly one done pulse.
REQ-032 A=0x00FF, shamt=8, SLL; reset pulled low after 4 edges -> S=0, busy=0 and done=0 immediately; no done pulse; a new start after release completes normally.

Source files
------------

// File: rtl/shift_unit_seq.sv
// Sequential one-bit-per-cycle shifter (SLL/SRL/SRA, optional ROL) with an IDLE/SHIFT/DONE FSM.
// Define SHIFT_ROTATE_EN to make mode 11 rotate left; otherwise mode 11 acts as SLL.
module shift_unit_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is only looked at in IDLE; the accepting edge captures A/shamt/mode,
  // busy stays high until the DONE cycle ends, and done pulses exactly once per accepted start.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_shift_d;
  logic [SHW-1:0]   count_q;
  logic [1:0]       op_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    s_shift_d = {s_q[WIDTH-2:0], 1'b0};
    case (op_q)
      2'b01:   s_shift_d = {1'b0, s_q[WIDTH-1:1]};
      2'b10:   s_shift_d = {s_q[WIDTH-1], s_q[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      2'b11:   s_shift_d = {s_q[WIDTH-2:0], s_q[WIDTH-1]};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      count_q <= '0;
      op_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            s_q     <= A;
            count_q <= shamt;
            op_q    <= mode;
            busy_q  <= 1'b1;
            if (shamt != '0) begin
              state_q <= SHIFT;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          s_q     <= s_shift_d;
          count_q <= count_q - 1'b1;
          if (count_q == SHW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign S         = s_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
